// File: rtl/bubble_sort_axil_slave_pkg.sv
// Shared constants, state type and address helper for the bubble sorter slave.
package bubble_sort_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // CTRL register bits (write-only, reads as zero).
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    // STATUS register fields.
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_COUNT_LSB = 16;

    typedef enum logic {IDLE, SORT} sort_state_t;

    // Byte offset of register word k.
    function automatic logic [31:0] word_offset(input int unsigned k);
        return 32'(k * 4);
    endfunction

endpackage

// File: rtl/bubble_sort_axil_slave_if.sv
// AXI4-Lite bundle between the block-design master and the sorter slave.
interface bubble_sort_axil_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bubble_sort_axil_slave_engine.sv
// Sequential compare-swap engine: one adjacent pair per cycle, shrinking
// pass bound, early exit on a pass without swaps.
module bubble_sort_engine
    import bubble_sort_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    localparam int IDX_W    = $clog2(NUM_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear_done,
    input  logic [31:0]      data [NUM_WORDS],
    output logic             busy,
    output logic             done,
    output logic [15:0]      swap_count,
    output logic             wb_en,
    output logic [IDX_W-1:0] wb_idx,
    output logic [31:0]      wb_lo,
    output logic [31:0]      wb_hi
);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_WORDS - 1);

    sort_state_t      state_q, state_d;
    logic [IDX_W-1:0] j_q, j_d, j_hi;
    logic [IDX_W-1:0] last_q, last_d;
    logic             swapped_q, swapped_d;
    logic             done_q, done_d;
    logic [15:0]      count_q, count_d;

    assign j_hi       = j_q + IDX_W'(1);
    assign busy       = (state_q == SORT);
    assign done       = done_q;
    assign swap_count = count_q;
    assign wb_idx     = j_q;
    assign wb_lo      = data[j_hi];
    assign wb_hi      = data[j_q];

    // State and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            j_q       <= '0;
            last_q    <= LAST_INIT;
            swapped_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            j_q       <= j_d;
            last_q    <= last_d;
            swapped_q <= swapped_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    // Next-state, compare decision and pass bookkeeping.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        j_d       = j_q;
        last_d    = last_q;
        swapped_d = swapped_q;
        done_d    = done_q;
        count_d   = count_q;
        wb_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SORT;
                    done_d    = 1'b0;
                    count_d   = '0;
                    j_d       = '0;
                    last_d    = LAST_INIT;
                    swapped_d = 1'b0;
                end else if (clear_done) begin
                    done_d = 1'b0;
                end
            end
            SORT: begin
                wb_en = (data[j_q] > data[j_hi]);
                if (wb_en && count_q != 16'hFFFF) count_d = count_q + 16'd1;
                if (j_q == last_q - IDX_W'(1)) begin
                    // End of pass: stop when nothing moved or the bound is exhausted.
                    if (!(swapped_q || wb_en) || last_q == IDX_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        last_d    = last_q - IDX_W'(1);
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_hi;
                    swapped_d = swapped_q || wb_en;
                end
            end
        endcase
    end
endmodule

// File: rtl/bubble_sort_axil_slave.sv
// AXI4-Lite front end: owns the data registers, decodes CTRL/STATUS and
// applies the engine's compare-swap write-backs.
module bubble_sort_axil_slave
    import bubble_sort_pkg::*;
#(
    parameter int NUM_WORDS          = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    bubble_sort_axil_if.slave s_axi,
    output logic              sort_done
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int WA_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [WA_W-1:0] CTRL_IDX   = WA_W'(word_offset(NUM_WORDS) >> 2);
    localparam logic [WA_W-1:0] STATUS_IDX = WA_W'(word_offset(NUM_WORDS + 1) >> 2);

    logic [DW-1:0]    data_q [NUM_WORDS];
    logic             aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
    logic [1:0]       b_resp_q;
    logic [DW-1:0]    r_data_q, rd_mux, status_word;
    logic [WA_W-1:0]  wr_idx, rd_idx;
    logic             wr_fire, wr_data_sel, wr_ctrl_sel, start, clear_done;
    logic             busy, done, wb_en;
    logic [15:0]      swap_count;
    logic [IDX_W-1:0] wb_idx, wb_idx_hi;
    logic [31:0]      wb_lo, wb_hi;
    logic             unused_bits;

    assign wr_idx      = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx      = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire     = aw_ready_q && s_axi.awvalid && s_axi.wvalid;
    assign wr_data_sel = (wr_idx < CTRL_IDX);
    assign wr_ctrl_sel = (wr_idx == CTRL_IDX);
    assign start       = wr_fire && wr_ctrl_sel && s_axi.wstrb[0] && s_axi.wdata[CTRL_START_BIT];
    assign clear_done  = wr_fire && wr_ctrl_sel && s_axi.wstrb[0] && s_axi.wdata[CTRL_CLEAR_BIT];
    assign wb_idx_hi   = wb_idx + IDX_W'(1);
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = aw_ready_q;
    assign s_axi.wready  = aw_ready_q;
    assign s_axi.bvalid  = b_valid_q;
    assign s_axi.bresp   = b_resp_q;
    assign s_axi.arready = ar_ready_q;
    assign s_axi.rvalid  = r_valid_q;
    assign s_axi.rdata   = r_data_q;
    assign s_axi.rresp   = RESP_OKAY;
    assign sort_done     = done;

    bubble_sort_engine #(.NUM_WORDS(NUM_WORDS)) u_engine (
        .clk        (S_AXI_ACLK),
        .rst_n      (S_AXI_ARESETN),
        .start      (start),
        .clear_done (clear_done),
        .data       (data_q),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .wb_en      (wb_en),
        .wb_idx     (wb_idx),
        .wb_lo      (wb_lo),
        .wb_hi      (wb_hi)
    );

    // Write address/data acceptance and write response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            aw_ready_q <= s_axi.awvalid && s_axi.wvalid && !b_valid_q && !aw_ready_q;
            if (wr_fire) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= (wr_data_sel && busy) ? RESP_SLVERR : RESP_OKAY;
            end else if (b_valid_q && s_axi.bready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Data registers: engine swaps while sorting, byte-lane AXI writes otherwise.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            // NOTE: the register array is reset because software may read it
            // before writing; this keeps it in flops rather than RAM.
            for (int k = 0; k < NUM_WORDS; k++) data_q[k] <= '0;
        end else if (wb_en) begin
            data_q[wb_idx]    <= wb_lo;
            data_q[wb_idx_hi] <= wb_hi;
        end else if (wr_fire && wr_data_sel && !busy) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) data_q[wr_idx[IDX_W-1:0]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    // Read data selection by word index.
    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY_BIT] = busy;
        status_word[STAT_DONE_BIT] = done;
        status_word[STAT_COUNT_LSB +: 16] = swap_count;
        rd_mux = '0;
        if (rd_idx < CTRL_IDX)        rd_mux = data_q[rd_idx[IDX_W-1:0]];
        else if (rd_idx == STATUS_IDX) rd_mux = status_word;
    end

    // Read address acceptance and registered read response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            ar_ready_q <= s_axi.arvalid && !r_valid_q && !ar_ready_q;
            if (ar_ready_q && s_axi.arvalid) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_mux;
            end else if (r_valid_q && s_axi.rready) begin
                r_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bubble_sort_axil_slave.sv
// Directed bench for the bubble sorter AXI4-Lite slave.
module tb_bubble_sort_axil_slave;
    import bubble_sort_pkg::*;

    logic clk;
    logic rst_n;
    logic sort_done;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rise_cyc = 0;
    logic prev_done = 1'b0;

    bubble_sort_axil_if #(.ADDR_W(5)) bus ();

    bubble_sort_axil_slave #(
        .NUM_WORDS(4), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .sort_done     (sort_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the cycle at which sort_done last rose.
    always @(negedge clk) begin
        if (sort_done === 1'b1 && prev_done !== 1'b1) rise_cyc = cyc;
        prev_done = sort_done;
    end

    // Called at a negedge; returns at a negedge.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic tok, output logic dn, output int hc);
        int n = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        while (bus.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        tok = (n < 50) && (bus.bvalid === 1'b0) && (bus.wready === 1'b1);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        tok  = tok && (bus.awready === 1'b0) && (bus.bvalid === 1'b1);
        resp = bus.bresp; dn = sort_done; hc = cyc;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        tok = tok && (bus.bvalid === 1'b0);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic ok);
        int n = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        while (bus.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        ok = (n < 50);
        @(negedge clk);
        bus.arvalid = 1'b0;
        ok = ok && (bus.rvalid === 1'b1);
        data = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        ok = ok && (bus.rvalid === 1'b0);
    endtask

    task automatic load4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v [4];
        logic [1:0] resp; logic tok, dn; int hc;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < 4; k++) axi_write(5'(word_offset(k)), v[k], 4'hF, resp, tok, dn, hc);
    endtask

    task automatic wait_done(output logic ok);
        int n = 0;
        while (sort_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        ok = (n < 200);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, sort_done} !== 6'b0 ||
            bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: rdy/vld=%b bresp=%b rresp=%b rdata=%h expected all zero",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, sort_done},
                     bus.bresp, bus.rresp, bus.rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic tok, dn, ok; int hc; logic [31:0] rd;
        for (int k = 0; k < 4; k++) begin
            axi_write(5'(word_offset(k)), 32'(k + 1), 4'hF, resp, tok, dn, hc);
            total++;
            if (resp !== RESP_OKAY || tok !== 1'b1) begin
                bad++;
                $display("FAIL write_data%0d: bresp=%b timing_ok=%b expected bresp=00 timing_ok=1", k, resp, tok);
            end
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(word_offset(k)), rd, resp, ok);
            total++;
            if (rd !== 32'(k + 1) || resp !== RESP_OKAY || ok !== 1'b1) begin
                bad++;
                $display("FAIL read_data%0d: rdata=%h rresp=%b ok=%b expected rdata=%h rresp=00 ok=1",
                         k, rd, resp, ok, 32'(k + 1));
            end
        end
    endtask

    task automatic test_sort_reverse();
        logic [1:0] resp; logic tok, dn, ok; int hc; logic [31:0] rd;
        load4(4, 3, 2, 1);
        axi_write(5'h10, 32'h1, 4'hF, resp, tok, dn, hc);
        wait_done(ok);
        total++;
        if (ok !== 1'b1 || rise_cyc - hc !== 6) begin
            bad++;
            $display("FAIL reverse_busy_cycles: got %0d ok=%b expected 6", rise_cyc - hc, ok);
        end
        axi_read(5'h14, rd, resp, ok);
        total++;
        if (rd !== 32'h0006_0002 || resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL reverse_status: got %h resp=%b expected 00060002 resp=00", rd, resp);
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(word_offset(k)), rd, resp, ok);
            total++;
            if (rd !== 32'(k + 1)) begin
                bad++;
                $display("FAIL reverse_data%0d: got %h expected %h", k, rd, 32'(k + 1));
            end
        end
        total++;
        if (sort_done !== 1'b1) begin
            bad++;
            $display("FAIL reverse_sort_done: got %b expected 1", sort_done);
        end
    endtask

    task automatic test_sort_sorted();
        logic [1:0] resp; logic tok, dn, ok; int hc; logic [31:0] rd;
        load4(1, 2, 3, 4);
        axi_write(5'h10, 32'h1, 4'hF, resp, tok, dn, hc);
        total++;
        if (dn !== 1'b0) begin
            bad++;
            $display("FAIL sorted_start_clears_done: got %b expected 0", dn);
        end
        wait_done(ok);
        total++;
        if (ok !== 1'b1 || rise_cyc - hc !== 3) begin
            bad++;
            $display("FAIL sorted_busy_cycles: got %0d ok=%b expected 3", rise_cyc - hc, ok);
        end
        axi_read(5'h14, rd, resp, ok);
        total++;
        if (rd !== 32'h0000_0002) begin
            bad++;
            $display("FAIL sorted_status: got %h expected 00000002", rd);
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(word_offset(k)), rd, resp, ok);
            total++;
            if (rd !== 32'(k + 1)) begin
                bad++;
                $display("FAIL sorted_data%0d: got %h expected %h", k, rd, 32'(k + 1));
            end
        end
    endtask

    task automatic test_busy_errors();
        logic [1:0] resp; logic tok, dn, ok; int hc, hc_start; logic [31:0] rd;
        load4(4, 3, 2, 1);
        axi_write(5'h10, 32'h1, 4'hF, resp, tok, dn, hc_start);
        axi_write(5'h00, 32'h0000_DEAD, 4'hF, resp, tok, dn, hc);
        total++;
        if (resp !== RESP_SLVERR) begin
            bad++;
            $display("FAIL busy_data_write_resp: got %b expected 10", resp);
        end
        axi_write(5'h10, 32'h1, 4'hF, resp, tok, dn, hc);
        total++;
        if (resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL busy_restart_resp: got %b expected 00", resp);
        end
        wait_done(ok);
        total++;
        if (ok !== 1'b1 || rise_cyc - hc_start !== 6) begin
            bad++;
            $display("FAIL busy_restart_ignored_cycles: got %0d ok=%b expected 6", rise_cyc - hc_start, ok);
        end
        axi_read(5'h14, rd, resp, ok);
        total++;
        if (rd !== 32'h0006_0002) begin
            bad++;
            $display("FAIL busy_status_after: got %h expected 00060002", rd);
        end
        axi_read(5'h00, rd, resp, ok);
        total++;
        if (rd !== 32'h1) begin
            bad++;
            $display("FAIL busy_data0_unchanged: got %h expected 00000001", rd);
        end
        axi_write(5'h10, 32'h2, 4'hF, resp, tok, dn, hc);
        axi_read(5'h14, rd, resp, ok);
        total++;
        if (rd !== 32'h0006_0000 || dn !== 1'b0) begin
            bad++;
            $display("FAIL clear_done: status=%h sort_done=%b expected 00060000 and 0", rd, dn);
        end
        // Restore done, then clear+start together: start wins, done stays low.
        axi_write(5'h10, 32'h1, 4'hF, resp, tok, dn, hc);
        wait_done(ok);
        axi_write(5'h10, 32'h3, 4'hF, resp, tok, dn, hc);
        total++;
        if (dn !== 1'b0) begin
            bad++;
            $display("FAIL clear_and_start_done: got %b expected 0", dn);
        end
        wait_done(ok);
        total++;
        if (ok !== 1'b1 || rise_cyc - hc !== 3) begin
            bad++;
            $display("FAIL clear_and_start_cycles: got %0d ok=%b expected 3", rise_cyc - hc, ok);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic tok, dn, ok; int hc; logic [31:0] rd;
        axi_write(5'h00, 32'h1122_3344, 4'hF, resp, tok, dn, hc);
        axi_write(5'h00, 32'hAABB_CCDD, 4'b0101, resp, tok, dn, hc);
        axi_read(5'h00, rd, resp, ok);
        total++;
        if (rd !== 32'h11BB_33DD) begin
            bad++;
            $display("FAIL strobe_merge: got %h expected 11bb33dd", rd);
        end
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, resp, tok, dn, hc);
        total++;
        if (resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL unmapped_write_resp: got %b expected 00", resp);
        end
        axi_read(5'h1C, rd, resp, ok);
        total++;
        if (rd !== 32'h0 || resp !== RESP_OKAY || ok !== 1'b1) begin
            bad++;
            $display("FAIL unmapped_read: got %h resp=%b ok=%b expected 00000000 resp=00", rd, resp, ok);
        end
        axi_read(5'h10, rd, resp, ok);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL ctrl_reads_zero: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic tok, dn, ok; int hc, n; logic [31:0] rd;
        load4(4, 3, 2, 1);
        axi_write(5'h10, 32'h1, 4'hF, resp, tok, dn, hc);
        bus.araddr = 5'h14; bus.arvalid = 1'b1; bus.rready = 1'b0;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        total++;
        if (bus.rvalid !== 1'b1 || bus.rdata[STAT_BUSY_BIT] !== 1'b1) begin
            bad++;
            $display("FAIL midsort_read_pending: rvalid=%b busy=%b expected 1 and 1", bus.rvalid, bus.rdata[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (bus.rvalid !== 1'b0 || sort_done !== 1'b0 || bus.rdata !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_drop: rvalid=%b sort_done=%b rdata=%h expected 0 0 0",
                     bus.rvalid, sort_done, bus.rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(5'h14, rd, resp, ok);
        total++;
        if (rd !== 32'h0) begin
            bad++;
            $display("FAIL reset_status: got %h expected 00000000", rd);
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(word_offset(k)), rd, resp, ok);
            total++;
            if (rd !== 32'h0) begin
                bad++;
                $display("FAIL reset_data%0d: got %h expected 00000000", k, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_sort_reverse();
        test_sort_sorted();
        test_busy_errors();
        test_strobe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
